// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_MEM,
    S_WB_ALU,
    S_BRANCH,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_RS1  = 2'b01;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_word_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; the controller is the master.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic       reg_write;
  logic       mem_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] aluop;
  logic       illegal;

  modport master (
    input  opcode, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, aluop, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, aluop, illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational state -> control-word decode; only FETCH also looks at mem_ready.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        // IR and PC must only capture once the fetched word is actually valid
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.aluop     = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.aluop     = ALUOP_FUNCT;
      end
      S_ADDR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_WB_ALU: ctrl.reg_write = 1'b1;
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = SRC_A_RS1;
        ctrl.alu_src_b     = SRC_B_RS2;
        ctrl.aluop         = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
      end
      S_TRAP:  ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with opcode latch and retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus,
  output logic [CNT_W-1:0]   instret
);

  state_t           state_reg;
  state_t           state_next;
  logic [6:0]       op_reg;
  logic [CNT_W-1:0] instret_reg;
  logic             retire;
  ctrl_word_t       ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      op_reg      <= '0;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      // ADDR needs load vs. store after the IR may have moved on
      if (state_reg == S_DECODE) op_reg <= bus.opcode;
      if (retire) instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_R:               state_next = S_EXEC_R;
          OP_I:               state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = S_ADDR;
          OP_BRANCH:          state_next = S_BRANCH;
          default:            state_next = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
      S_ADDR:   state_next = (op_reg == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (bus.mem_ready) state_next = S_WB_MEM;
      S_MEM_WR: begin
        if (bus.mem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_IDLE;
    endcase
  end

  ctrl_decode u_decode (
    .state     (state_reg),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.iord          = ctrl.iord;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.aluop         = ctrl.aluop;
  assign bus.illegal       = ctrl.illegal;
  assign instret           = instret_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control word and instret checks.
module tb_multicycle_ctrl;

  // Control word packing: {mem_read, mem_write, iord, ir_write, pc_write,
  // pc_write_cond, reg_write, mem_to_reg, alu_src_a, alu_src_b, aluop, illegal}
  localparam logic [14:0] W_IDLE       = 15'b00000000_0000000;
  localparam logic [14:0] W_FETCH_RDY  = 15'b10011000_0001000;
  localparam logic [14:0] W_FETCH_WAIT = 15'b10000000_0001000;
  localparam logic [14:0] W_DECODE     = 15'b00000000_0011000;
  localparam logic [14:0] W_EXEC_R     = 15'b00000000_0100100;
  localparam logic [14:0] W_EXEC_I     = 15'b00000000_0111100;
  localparam logic [14:0] W_ADDR       = 15'b00000000_0111000;
  localparam logic [14:0] W_MEM_RD     = 15'b10100000_0000000;
  localparam logic [14:0] W_MEM_WR     = 15'b01100000_0000000;
  localparam logic [14:0] W_WB_ALU     = 15'b00000010_0000000;
  localparam logic [14:0] W_WB_MEM     = 15'b00000011_0000000;
  localparam logic [14:0] W_BRANCH     = 15'b00000100_0100010;
  localparam logic [14:0] W_TRAP       = 15'b00000000_0000001;

  localparam logic [6:0] T_OP_R      = 7'b0110011;
  localparam logic [6:0] T_OP_I      = 7'b0010011;
  localparam logic [6:0] T_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] T_OP_STORE  = 7'b0100011;
  localparam logic [6:0] T_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] T_OP_BAD    = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instret32;
  logic [3:0]  instret4;
  logic [14:0] obs;
  logic [14:0] obs4;
  int          n_cmp = 0;
  int          n_err = 0;

  multicycle_ctrl_if bus32 ();
  multicycle_ctrl_if bus4 ();

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus32), .instret(instret32)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .instret(instret4)
  );

  always #5 clk = ~clk;

  assign obs = {bus32.mem_read, bus32.mem_write, bus32.iord, bus32.ir_write,
                bus32.pc_write, bus32.pc_write_cond, bus32.reg_write,
                bus32.mem_to_reg, bus32.alu_src_a, bus32.alu_src_b,
                bus32.aluop, bus32.illegal};
  assign obs4 = {bus4.mem_read, bus4.mem_write, bus4.iord, bus4.ir_write,
                 bus4.pc_write, bus4.pc_write_cond, bus4.reg_write,
                 bus4.mem_to_reg, bus4.alu_src_a, bus4.alu_src_b,
                 bus4.aluop, bus4.illegal};

  task automatic drive(input logic [6:0] op, input logic rdy);
    bus32.opcode    = op;
    bus32.mem_ready = rdy;
    bus4.opcode     = op;
    bus4.mem_ready  = rdy;
  endtask

  // Leaves the bench at a falling edge with both DUTs in IDLE, rst low.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(7'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(T_OP_R, 1'b1);
    #1;
    n_cmp++;
    if (obs !== W_IDLE) begin
      n_err++; $display("FAIL reset_word got %b want %b", obs, W_IDLE);
    end
    n_cmp++;
    if (instret32 !== 32'd0) begin
      n_err++; $display("FAIL reset_instret got %0d want 0", instret32);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== W_IDLE) begin
      n_err++; $display("FAIL reset_release_idle got %b want %b", obs, W_IDLE);
    end
    $display("reset: word=%b instret=%0d", obs, instret32);
  endtask

  task automatic test_rtype();
    logic [14:0] exp_w [5];
    exp_w[0] = W_FETCH_RDY; exp_w[1] = W_DECODE; exp_w[2] = W_EXEC_R;
    exp_w[3] = W_WB_ALU;    exp_w[4] = W_FETCH_RDY;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(T_OP_R, 1'b1);
      #1;
      n_cmp++;
      if (obs !== exp_w[i]) begin
        n_err++; $display("FAIL rtype_c%0d got %b want %b", i, obs, exp_w[i]);
      end
      n_cmp++;
      if (instret32 !== ((i == 4) ? 32'd1 : 32'd0)) begin
        n_err++; $display("FAIL rtype_instret_c%0d got %0d want %0d", i, instret32, (i == 4) ? 1 : 0);
      end
    end
    $display("rtype: instret=%0d", instret32);
  endtask

  task automatic test_itype();
    logic [14:0] exp_w [5];
    exp_w[0] = W_FETCH_RDY; exp_w[1] = W_DECODE; exp_w[2] = W_EXEC_I;
    exp_w[3] = W_WB_ALU;    exp_w[4] = W_FETCH_RDY;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(T_OP_I, 1'b1);
      #1;
      n_cmp++;
      if (obs !== exp_w[i]) begin
        n_err++; $display("FAIL itype_c%0d got %b want %b", i, obs, exp_w[i]);
      end
    end
    n_cmp++;
    if (instret32 !== 32'd1) begin
      n_err++; $display("FAIL itype_instret got %0d want 1", instret32);
    end
    $display("itype: instret=%0d", instret32);
  endtask

  // Load with two wait cycles in MEM_RD; opcode goes bad after DECODE.
  task automatic test_load_wait();
    logic [14:0] exp_w [8];
    logic        rdy_v [8];
    exp_w[0] = W_FETCH_RDY; exp_w[1] = W_DECODE; exp_w[2] = W_ADDR;
    exp_w[3] = W_MEM_RD;    exp_w[4] = W_MEM_RD; exp_w[5] = W_MEM_RD;
    exp_w[6] = W_WB_MEM;    exp_w[7] = W_FETCH_RDY;
    rdy_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive((i <= 1) ? T_OP_LOAD : T_OP_BAD, rdy_v[i]);
      #1;
      n_cmp++;
      if (obs !== exp_w[i]) begin
        n_err++; $display("FAIL load_c%0d got %b want %b", i, obs, exp_w[i]);
      end
      n_cmp++;
      if (instret32 !== ((i == 7) ? 32'd1 : 32'd0)) begin
        n_err++; $display("FAIL load_instret_c%0d got %0d want %0d", i, instret32, (i == 7) ? 1 : 0);
      end
    end
    $display("load: 7-cycle instruction, instret=%0d", instret32);
  endtask

  // One fetch wait cycle, then a 3-cycle branch.
  task automatic test_branch();
    logic [14:0] exp_w [5];
    logic        rdy_v [5];
    exp_w[0] = W_FETCH_WAIT; exp_w[1] = W_FETCH_RDY; exp_w[2] = W_DECODE;
    exp_w[3] = W_BRANCH;     exp_w[4] = W_FETCH_RDY;
    rdy_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(T_OP_BRANCH, rdy_v[i]);
      #1;
      n_cmp++;
      if (obs !== exp_w[i]) begin
        n_err++; $display("FAIL branch_c%0d got %b want %b", i, obs, exp_w[i]);
      end
    end
    n_cmp++;
    if (instret32 !== 32'd1) begin
      n_err++; $display("FAIL branch_instret got %0d want 1", instret32);
    end
    $display("branch: instret=%0d", instret32);
  endtask

  task automatic test_store();
    logic [14:0] exp_w [5];
    exp_w[0] = W_FETCH_RDY; exp_w[1] = W_DECODE; exp_w[2] = W_ADDR;
    exp_w[3] = W_MEM_WR;    exp_w[4] = W_FETCH_RDY;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(T_OP_STORE, 1'b1);
      #1;
      n_cmp++;
      if (obs !== exp_w[i]) begin
        n_err++; $display("FAIL store_c%0d got %b want %b", i, obs, exp_w[i]);
      end
    end
    n_cmp++;
    if (instret32 !== 32'd1) begin
      n_err++; $display("FAIL store_instret got %0d want 1", instret32);
    end
    $display("store: instret=%0d", instret32);
  endtask

  task automatic test_reset_mid_write();
    logic [14:0] exp_w [5];
    logic        rdy_v [5];
    exp_w[0] = W_FETCH_RDY; exp_w[1] = W_DECODE; exp_w[2] = W_ADDR;
    exp_w[3] = W_MEM_WR;    exp_w[4] = W_MEM_WR;
    rdy_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(T_OP_STORE, rdy_v[i]);
      #1;
      n_cmp++;
      if (obs !== exp_w[i]) begin
        n_err++; $display("FAIL rstwr_c%0d got %b want %b", i, obs, exp_w[i]);
      end
    end
    bus32.mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== W_IDLE) begin
      n_err++; $display("FAIL rstwr_drop got %b want %b", obs, W_IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (instret32 !== 32'd0) begin
      n_err++; $display("FAIL rstwr_instret got %0d want 0", instret32);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (obs !== W_FETCH_RDY) begin
      n_err++; $display("FAIL rstwr_refetch got %b want %b", obs, W_FETCH_RDY);
    end
    $display("reset_mid_write: word=%b instret=%0d", obs, instret32);
  endtask

  // One R-type retires, then an illegal opcode traps for 20 cycles.
  task automatic test_trap();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(T_OP_R, 1'b1);
    end
    @(negedge clk);
    drive(T_OP_BAD, 1'b1);
    #1;
    n_cmp++;
    if (obs !== W_FETCH_RDY) begin
      n_err++; $display("FAIL trap_fetch got %b want %b", obs, W_FETCH_RDY);
    end
    @(negedge clk);
    drive(T_OP_BAD, 1'b1);
    #1;
    n_cmp++;
    if (obs !== W_DECODE) begin
      n_err++; $display("FAIL trap_decode got %b want %b", obs, W_DECODE);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive((i % 2 == 0) ? T_OP_R : T_OP_LOAD, i[0]);
      #1;
      n_cmp++;
      if (obs !== W_TRAP) begin
        n_err++; $display("FAIL trap_c%0d got %b want %b", i, obs, W_TRAP);
      end
      n_cmp++;
      if (instret32 !== 32'd1) begin
        n_err++; $display("FAIL trap_instret_c%0d got %0d want 1", i, instret32);
      end
    end
    $display("trap: word=%b instret=%0d", obs, instret32);
  endtask

  // 16 back-to-back R-types: the 4-bit counter walks 1..15 then wraps to 0.
  task automatic test_back_to_back_wrap();
    do_reset();
    for (int i = 0; i <= 64; i++) begin
      @(negedge clk);
      drive(T_OP_R, 1'b1);
      #1;
      if (i % 4 == 0) begin
        n_cmp++;
        if (obs4 !== W_FETCH_RDY) begin
          n_err++; $display("FAIL wrap_fetch_i%0d got %b want %b", i, obs4, W_FETCH_RDY);
        end
        n_cmp++;
        if (instret4 !== 4'((i / 4) % 16)) begin
          n_err++; $display("FAIL wrap_instret_i%0d got %0d want %0d", i, instret4, (i / 4) % 16);
        end
      end
    end
    n_cmp++;
    if (instret32 !== 32'd16) begin
      n_err++; $display("FAIL wrap_instret32 got %0d want 16", instret32);
    end
    $display("back_to_back: instret4=%0d instret32=%0d", instret4, instret32);
  endtask

  initial begin
    drive(7'd0, 1'b0);
    test_reset();
    test_rtype();
    test_itype();
    test_load_wait();
    test_branch();
    test_store();
    test_reset_mid_write();
    test_trap();
    test_back_to_back_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
